// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared ACIA receive-FIFO constants and status packing
package acia_pkg;

    localparam int ACIA_DEPTH_LOG2 = 4;

    localparam int ST_RDRF = 0;
    localparam int ST_FE   = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_FULL = 3;
    localparam int ST_IRQ  = 7;

    localparam int CTRL_IE    = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_CLR   = 2;

    function automatic logic [7:0] acia_status(
        input logic rdrf,
        input logic fe,
        input logic ovr,
        input logic full,
        input logic irq
    );
        logic [7:0] s;
        s          = 8'h00;
        s[ST_RDRF] = rdrf;
        s[ST_FE]   = fe;
        s[ST_OVR]  = ovr;
        s[ST_FULL] = full;
        s[ST_IRQ]  = irq;
        return s;
    endfunction

endpackage

// File: rtl/acia_rx_fifo.sv
// rtl/acia_rx_fifo.sv - ACIA receive FIFO with status/control register and interrupt
module acia_rx_fifo
    import acia_pkg::*;
#(
    parameter int DEPTH_LOG2 = ACIA_DEPTH_LOG2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_dat,
    input  logic       rx_stb,
    input  logic       rx_err,
    input  logic       cs,
    input  logic       we,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(1 << DEPTH_LOG2);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [7:0] mem [1 << DEPTH_LOG2];

    ptr_t wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    cnt_t count, count_n;
    logic stb_q, err_q;
    logic fe, ovr, ie;
    logic fe_n, ovr_n, ie_n;

    logic push, fe_set, rd_data, rd_stat, ctrl_wr, flush, clr;
    logic full, rdrf, pop, push_ok, ovr_set, unused_din;

    assign unused_din = ^din[7:3];

    assign push    = rx_stb & ~stb_q;
    assign fe_set  = rx_err & ~err_q;
    assign rd_data = cs & ~we & ~rs;
    assign rd_stat = cs & ~we & rs;
    assign ctrl_wr = cs & we & rs;
    assign flush   = ctrl_wr & din[CTRL_FLUSH];
    assign clr     = ctrl_wr & din[CTRL_CLR];

    assign rdrf    = (count != '0);
    assign full    = (count == DEPTH_C);
    assign pop     = rd_data & rdrf;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (push_ok) wr_ptr_n = wr_ptr + PTR_ONE;
            if (pop)     rd_ptr_n = rd_ptr + PTR_ONE;
            if (push_ok && !pop)      count_n = count + CNT_ONE;
            else if (pop && !push_ok) count_n = count - CNT_ONE;
        end
    end

    // Setting a flag wins over a same-cycle clear.
    always_comb begin
        ie_n  = ctrl_wr ? din[CTRL_IE] : ie;
        fe_n  = fe_set  | (fe  & ~clr);
        ovr_n = ovr_set | (ovr & ~clr);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= rx_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stb_q  <= 1'b1;
            err_q  <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fe     <= 1'b0;
            ovr    <= 1'b0;
            ie     <= 1'b0;
            irq    <= 1'b0;
            dout   <= 8'h00;
        end else begin
            stb_q  <= rx_stb;
            err_q  <= rx_err;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            fe     <= fe_n;
            ovr    <= ovr_n;
            ie     <= ie_n;
            irq    <= ie_n & ((count_n != '0) | fe_n | ovr_n);
            if (rd_data)
                dout <= rdrf ? mem[rd_ptr] : 8'h00;
            else if (rd_stat)
                dout <= acia_status(rdrf, fe, ovr, full, irq);
        end
    end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// tb/tb_acia_rx_fifo.sv - directed self-checking bench for acia_rx_fifo
module tb_acia_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    int errors = 0;
    int checks = 0;
    logic [7:0] rd;

    acia_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset_n(reset_n), .rx_dat(rx_dat), .rx_stb(rx_stb),
        .rx_err(rx_err), .cs(cs), .we(we), .rs(rs), .din(din),
        .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic r, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; rs = r;
        tick();
        cs = 1'b0;
        d = dout;
    endtask

    task automatic bus_write(input logic r, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; rs = r; din = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_dat = b;
        rx_stb = 1'b1;
        repeat (8) tick();
        rx_stb = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; rx_dat = 8'h00; rx_stb = 1'b1; rx_err = 1'b1;
        cs = 1'b0; we = 1'b0; rs = 1'b0; din = 8'h00;
        repeat (3) tick();
        chk("reset_dout", dout, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);

        // Levels already high at release must not push or flag FE
        reset_n = 1'b1;
        repeat (2) tick();
        rx_stb = 1'b0; rx_err = 1'b0;
        tick();
        bus_read(1'b1, rd); chk("status_after_release", rd, 8'h00);

        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        bus_read(1'b1, rd); chk("status_three", rd, 8'h01);
        bus_write(1'b0, 8'hFF);
        bus_read(1'b0, rd); chk("read_41", rd, 8'h41);
        bus_read(1'b0, rd); chk("read_42", rd, 8'h42);
        bus_read(1'b0, rd); chk("read_43", rd, 8'h43);
        repeat (4) tick();
        chk("dout_hold", dout, 8'h43);
        bus_read(1'b0, rd); chk("read_empty", rd, 8'h00);
        bus_read(1'b1, rd); chk("status_empty", rd, 8'h00);

        for (int i = 0; i < 17; i++) push_byte(8'(i));
        bus_read(1'b1, rd); chk("status_full_ovr", rd, 8'h0D);
        for (int i = 0; i < 16; i++) begin
            bus_read(1'b0, rd); chk($sformatf("read_full_%0d", i), rd, 8'(i));
        end
        bus_read(1'b1, rd); chk("status_drained", rd, 8'h04);

        bus_write(1'b1, 8'h04);
        bus_read(1'b1, rd); chk("status_cleared", rd, 8'h00);
        for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i));
        bus_read(1'b1, rd); chk("status_full_again", rd, 8'h09);
        // Read coincident with the push edge of 8'hAA
        rx_dat = 8'hAA; rx_stb = 1'b1;
        bus_read(1'b0, rd); chk("read_coincident", rd, 8'h50);
        rx_stb = 1'b0;
        tick();
        bus_read(1'b1, rd); chk("status_no_ovr", rd, 8'h09);
        for (int i = 1; i < 16; i++) begin
            bus_read(1'b0, rd); chk($sformatf("read_wrap_%0d", i), rd, 8'h50 + 8'(i));
        end
        bus_read(1'b0, rd); chk("read_aa", rd, 8'hAA);
        bus_read(1'b1, rd); chk("status_after_aa", rd, 8'h00);

        bus_write(1'b1, 8'h01);
        chk("irq_ie_empty", {7'b0, irq}, 8'h00);
        rx_err = 1'b1;
        tick();
        chk("irq_fe", {7'b0, irq}, 8'h01);
        bus_read(1'b1, rd); chk("status_fe", rd, 8'h82);
        bus_write(1'b1, 8'h05);
        chk("irq_fe_cleared", {7'b0, irq}, 8'h00);
        bus_read(1'b1, rd); chk("status_fe_cleared", rd, 8'h00);
        rx_err = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        bus_read(1'b1, rd); chk("status_five", rd, 8'h81);
        bus_write(1'b1, 8'h03);
        chk("irq_flushed", {7'b0, irq}, 8'h00);
        bus_read(1'b1, rd); chk("status_flushed", rd, 8'h00);
        // Flush beats a same-cycle push
        rx_dat = 8'h99; rx_stb = 1'b1;
        bus_write(1'b1, 8'h03);
        rx_stb = 1'b0;
        tick();
        bus_read(1'b1, rd); chk("status_flush_vs_push", rd, 8'h00);
        // FE set beats a same-cycle clear
        rx_err = 1'b1;
        bus_write(1'b1, 8'h05);
        bus_read(1'b1, rd); chk("status_fe_vs_clear", rd, 8'h82);
        rx_err = 1'b0;
        tick();
        bus_write(1'b1, 8'h05);

        push_byte(8'h77); push_byte(8'h78);
        bus_read(1'b0, rd); chk("read_77", rd, 8'h77);
        chk("irq_before_reset", {7'b0, irq}, 8'h01);
        rx_dat = 8'h79; rx_stb = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_dout", dout, 8'h00);
        chk("async_reset_irq", {7'b0, irq}, 8'h00);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        rx_stb = 1'b0;
        tick();
        bus_read(1'b1, rd); chk("status_post_reset", rd, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acia_rx_fifo.md
ACIA_RX_FIFO -- requirements
Module: acia_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2**DEPTH_LOG2 entries.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_dat  input  8  received byte from the serial receiver.
REQ-005 SHALL have port rx_stb  input  1  received-byte strobe; level, may stay high for many clk cycles.
REQ-006 SHALL have port rx_err  input  1  framing-error level from the receiver.
REQ-007 SHALL have port cs  input  1  bus select, one-cycle qualified access strobe.
REQ-008 SHALL have port we  input  1  bus write enable (1 = write).
REQ-009 SHALL have port rs  input  1  register select (0 = data, 1 = status/control).
REQ-010 SHALL have port din  input  8  bus write data.
REQ-011 SHALL have port dout  output  8  registered bus read data.
REQ-012 SHALL have port irq  output  1  interrupt request, active high.

Function
REQ-013 SHALL detect the 0->1 edge of rx_stb and push rx_dat exactly once per edge.
REQ-014 SHALL detect the 0->1 edge of rx_err and set sticky FE flag.
REQ-015 SHALL implement a circular buffer with DEPTH_LOG2-bit read/write pointers wrapping at 2**DEPTH_LOG2 and a (DEPTH_LOG2+1)-bit count 0..2**DEPTH_LOG2.
REQ-016 SHALL pop on cs & ~we & ~rs when count > 0; dout = head entry, valid the cycle after the access.
REQ-017 SHALL, on a data read with count = 0, not pop, leave pointers unchanged and return 8'h00.
REQ-018 SHALL, on push when full without a same-cycle pop, discard the byte and set sticky OVR flag.
REQ-019 SHALL, on simultaneous push and pop, perform both; count unchanged; when full, byte accepted, OVR not set.
REQ-020 SHALL return on cs & ~we & rs status: bit0 RDRF (count>0), bit1 FE, bit2 OVR, bit3 FULL, bits6:4 0, bit7 irq, registered one cycle.
REQ-021 SHALL, on cs & we & rs, take control: din[0] IE latched; din[1] flush (pointers, count to 0, one-shot); din[2] clear FE and OVR (one-shot).
REQ-022 SHALL ignore cs & we & ~rs (no state change).
REQ-023 SHALL give flush priority over a same-cycle push: FIFO empty afterwards.
REQ-024 SHALL give a same-cycle FE/OVR set priority over clear-errors: flag remains 1.
REQ-025 SHALL drive irq registered = IE & (RDRF | FE | OVR), updated one cycle after the causing event.
REQ-026 SHALL hold dout between accesses (no change without cs & ~we).

Reset
REQ-027 SHALL on reset_n low asynchronously clear pointers, count, FE, OVR, IE, dout (8'h00), irq (0), and edge-detect registers.
REQ-028 SHALL reset the rx_stb/rx_err edge-detect registers to 1, so a level already high at reset release does not push or set FE.
REQ-029 SHALL not require buffer storage contents to reset.

Structure
REQ-030 SHALL place status bit indices, control bit indices and default DEPTH_LOG2 in a shared acia package.
REQ-031 SHALL be one module; storage inferable as block RAM or registers; no sub-module required.

Verification
REQ-032 SHALL test: reset, three rx_stb pulses (each held 8 clk) with bytes 8'h41,8'h42,8'h43 -> status RDRF=1, three data reads return 41,42,43, fourth read returns 00, RDRF=0.
REQ-033 SHALL test: 17 bytes 8'h00..8'h10 pushed into depth 16 -> FULL=1, OVR=1, reads return 00..0F, then RDRF=0.
REQ-034 SHALL test: full FIFO, data read coincident with rx_stb edge carrying 8'hAA -> OVR=0, count stays 16, last entry read is AA.
REQ-035 SHALL test: IE=1, rx_err rising edge -> FE=1, irq=1 next cycle; write control 8'h05 -> FE=0, irq=0 if empty.
REQ-036 SHALL test: five bytes buffered, control write 8'h03 -> RDRF=0, irq=0; reset_n low mid-push -> all outputs 0 immediately.
